// File: rtl/fmc_pkg.sv
// fmc_pkg: shared definitions for the FMC register bank.
//   fmc_state_e      - host-access FSM state encoding
//   FMC_DEF_*        - default parameter values for fmc_reg_bank
package fmc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RD   = 3'd4,
    ST_DONE = 3'd5
  } fmc_state_e;

  localparam int          FMC_DEF_DW   = 16;
  localparam int          FMC_DEF_NCH  = 32;
  localparam logic [15:0] FMC_DEF_BASE = 16'h0000;
  localparam int          FMC_DEF_SYNC = 2;

endpackage

// File: rtl/fmc_sync.sv
// fmc_sync: multi-stage flip-flop synchronizer for one asynchronous control line.
//   clk   - destination clock
//   rst   - asynchronous active-high reset, clears every stage to 0
//   d     - asynchronous input
//   q     - synchronized output (last stage)
module fmc_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[DEPTH-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/fmc_reg_bank.sv
// fmc_reg_bank: register bank behind an STM32-style multiplexed FMC host bus.
//   clk, rst                    - system clock, asynchronous active-high reset
//   fpga_cs_ne1, fpga_nl_nadv   - chip select / address valid (active low, async)
//   fpga_wr_nwe, fpga_rd_noe    - write / read strobes (active low, async)
//   fpga_db                     - multiplexed address/data bus
//   rd_vals                     - fabric-to-host values, channel k at [k*DW +: DW]
//   wr_regs                     - host-to-fabric registers, same packing
//   wr_pulse, rd_pulse          - one-clk per-channel write / read strobes
//   bus_err, err_clr            - sticky out-of-range flag and its clear
//
// Host timing assumption: ADDSET and DATAST are each at least SYNC+3 clk
// periods, and the address stays on the bus a few clks after NADV rises.
//
// state | meaning
// IDLE  | waiting for a fresh chip-select falling edge with NADV low
// ADDR  | address phase, address register follows the bus every clk
// WAIT  | address latched, waiting for a write or read strobe
// WR    | write data sampled on entry, committed on the following clk
// RD    | read buffer snapshotted on entry, driven while raw CS/NOE are low
// DONE  | strobe released, waiting for chip select to rise
module fmc_reg_bank
  import fmc_pkg::*;
#(
  parameter int          DW   = FMC_DEF_DW,
  parameter int          NCH  = FMC_DEF_NCH,
  parameter logic [15:0] BASE = FMC_DEF_BASE,
  parameter int          SYNC = FMC_DEF_SYNC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fpga_cs_ne1,
  input  logic              fpga_nl_nadv,
  input  logic              fpga_wr_nwe,
  input  logic              fpga_rd_noe,
  inout  wire  [DW-1:0]     fpga_db,
  input  logic [NCH*DW-1:0] rd_vals,
  output logic [NCH*DW-1:0] wr_regs,
  output logic [NCH-1:0]    wr_pulse,
  output logic [NCH-1:0]    rd_pulse,
  output logic              bus_err,
  input  logic              err_clr
);

  logic cs_s, nadv_s, nwe_s, noe_s;

  fmc_sync #(.DEPTH(SYNC)) u_sync_cs   (.clk(clk), .rst(rst), .d(fpga_cs_ne1),  .q(cs_s));
  fmc_sync #(.DEPTH(SYNC)) u_sync_nadv (.clk(clk), .rst(rst), .d(fpga_nl_nadv), .q(nadv_s));
  fmc_sync #(.DEPTH(SYNC)) u_sync_nwe  (.clk(clk), .rst(rst), .d(fpga_wr_nwe),  .q(nwe_s));
  fmc_sync #(.DEPTH(SYNC)) u_sync_noe  (.clk(clk), .rst(rst), .d(fpga_rd_noe),  .q(noe_s));

  fmc_state_e          state_q, state_d;
  logic [DW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [DW-1:0]       rbuf_q, rbuf_d;
  logic                wr_pend_q, wr_pend_d;
  logic                armed_q, armed_d;
  logic [NCH*DW-1:0]   wr_regs_q, wr_regs_d;
  logic [NCH-1:0]      wr_pulse_q, wr_pulse_d;
  logic [NCH-1:0]      rd_pulse_q, rd_pulse_d;
  logic                bus_err_q, bus_err_d;
  logic                new_err;

  // Address decode, done in 17 bits so addresses below BASE never wrap into range.
  logic [16:0]    addr_ext;
  logic [16:0]    off;
  logic           in_range;
  logic [NCH-1:0] ch_hit;
  logic [DW-1:0]  rd_sel;

  always_comb begin
    addr_ext = 17'(addr_q);
    off      = addr_ext - {1'b0, BASE};
    in_range = (addr_ext >= {1'b0, BASE}) && (off < 17'(NCH));
    rd_sel   = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_hit[k] = in_range && (off == 17'(k));
      if (ch_hit[k]) begin
        rd_sel = rd_vals[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    wr_pend_d  = wr_pend_q;
    // The synchronizers come out of reset at 0, which looks like an active
    // chip select; requiring CS to be seen high first makes IDLE wait for a
    // genuine falling edge.
    armed_d    = armed_q | cs_s;
    wr_regs_d  = wr_regs_q;
    wr_pulse_d = '0;
    rd_pulse_d = '0;
    new_err    = 1'b0;

    if (cs_s && (state_q != ST_IDLE)) begin
      // Chip select released: from DONE this is the normal exit, elsewhere
      // it abandons the access and drops any pending write.
      state_d   = ST_IDLE;
      wr_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (armed_q && !cs_s && !nadv_s) begin
            state_d = ST_ADDR;
            armed_d = 1'b0;
          end
        end
        ST_ADDR: begin
          addr_d = fpga_db;
          if (nadv_s) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!nwe_s) begin
            state_d   = ST_WR;
            wdata_d   = fpga_db;
            wr_pend_d = 1'b1;
          end else if (!noe_s) begin
            state_d    = ST_RD;
            rbuf_d     = rd_sel;
            rd_pulse_d = ch_hit;
            new_err    = !in_range;
          end
        end
        ST_WR: begin
          if (wr_pend_q) begin
            wr_pend_d  = 1'b0;
            wr_pulse_d = ch_hit;
            new_err    = !in_range;
            for (int k = 0; k < NCH; k++) begin
              if (ch_hit[k]) begin
                wr_regs_d[k*DW +: DW] = wdata_q;
              end
            end
          end
          if (nwe_s) begin
            state_d = ST_DONE;
          end
        end
        ST_RD: begin
          if (noe_s) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // A new error wins over a simultaneous clear.
    bus_err_d = (bus_err_q & ~err_clr) | new_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      wr_pend_q  <= 1'b0;
      armed_q    <= 1'b0;
      wr_regs_q  <= '0;
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      wr_pend_q  <= wr_pend_d;
      armed_q    <= armed_d;
      wr_regs_q  <= wr_regs_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Output enable uses the raw pins so the bus is released as soon as the
  // host lifts NOE or CS, without waiting for the synchronizers.
  assign fpga_db = ((state_q == ST_RD) && !fpga_cs_ne1 && !fpga_rd_noe) ? rbuf_q : {DW{1'bz}};

  assign wr_regs  = wr_regs_q;
  assign wr_pulse = wr_pulse_q;
  assign rd_pulse = rd_pulse_q;
  assign bus_err  = bus_err_q;

endmodule
